dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit memory words (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the number of wait cycles before an access commits (0 allowed).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port req  input  1  SHALL be the access request, sampled only in IDLE.
REQ-006 Port we  input  1  SHALL select write (1) or read (0); driven from the CPU MemWrite.
REQ-007 Port memOp  input  2  SHALL encode access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-008 Port addr  input  32  SHALL be the byte address (CPU aluout).
REQ-009 Port wdata  input  32  SHALL be the store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 Port rdata  output  32  SHALL return the full aligned word; load extraction is done by the register file using memOp/addr[1:0].
REQ-011 Port ack  output  1  SHALL pulse for exactly one cycle when an access completes.
REQ-012 Port busy  output  1  SHALL be high while an access is outstanding; the CPU stalls on it.
REQ-013 Port err  output  1  SHALL flag a misaligned access; it is constant 0 when DMEM_MISALIGN_TRAP_EN is undefined.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP.
REQ-015 IDLE with req=1 at an edge SHALL capture we, memOp, addr, wdata and go to WAIT with counter=WAIT_CYCLES, or directly to RESP (committing the access on that edge) when WAIT_CYCLES=0.
REQ-016 WAIT SHALL last exactly WAIT_CYCLES cycles; on its final edge the access SHALL commit and the state SHALL become RESP.
REQ-017 RESP SHALL assert ack for one cycle with rdata valid, then return to IDLE unconditionally; back-to-back requests are therefore accepted no earlier than the edge after RESP.
REQ-018 Latency: with the request sampled at edge E, commit occurs at edge E+WAIT_CYCLES and ack is high during the following cycle.
REQ-019 busy SHALL be high in WAIT and RESP, low in IDLE; req in WAIT/RESP SHALL be ignored.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored (wrap-around).
REQ-021 Writes SHALL be little-endian byte-lane masked: byte -> lane addr[1:0]; half -> lanes {1,0} if addr[1]=0 else {3,2}; word -> all lanes; unselected lanes unchanged.
REQ-022 Reads SHALL return the addressed word as it stood before the commit edge; a write access SHALL return the pre-write word on rdata.
REQ-023 Captured inputs SHALL be used for the whole access; input changes after capture SHALL have no effect.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, counter=0, ack=0, busy=0, err=0, rdata=0, taking priority over all other events.
REQ-025 Reset during WAIT SHALL discard the pending access; an uncommitted write SHALL never reach memory.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With DMEM_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL suppress the write, return rdata=0, and assert err together with ack for that one cycle.
REQ-028 Without DMEM_MISALIGN_TRAP_EN, misaligned low address bits SHALL be ignored (half uses addr[1] only, word uses none) and err SHALL be tied 0.

Verification
REQ-029 WAIT_CYCLES=2: write word 0xDEADBEEF at 0x10, read 0x10 -> ack exactly 2 edges after req sample each time, rdata=0xDEADBEEF, busy high 3 cycles per access.
REQ-030 Word 0x11223344 at 0x20, byte write 0xAA at 0x22, half write 0x5566 at 0x20 -> read 0x20 returns 0x11AA5566.
REQ-031 req held high continuously for 3 accesses -> exactly 3 ack pulses, each separated by at least one IDLE cycle; req during busy never starts an extra access.
REQ-032 Reset asserted in WAIT of a write 0xCAFEF00D to 0x40 (previously 0) -> outputs zero on next cycle, no ack, later read of 0x40 returns 0.
REQ-033 DEPTH_WORDS=1024: write 0x12345678 at 0x1000 -> read 0x0 returns 0x12345678 (wrap); WAIT_CYCLES=0 variant -> ack on cycle after req sample.
REQ-034 Macro defined: word write 0xFFFFFFFF to 0x31 -> err=1 with ack, rdata=0, word at 0x30 unchanged; macro undefined: same stimulus writes 0xFFFFFFFF to 0x30, err=0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Wait-state data memory controller: IDLE/WAIT/RESP handshake, byte-lane masked writes.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  memOp,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           we_q;
    logic [1:0]     op_q;
    logic [31:0]    addr_q, wdata_q;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic [31:0]    mem [DEPTH_WORDS];

    logic           idle, commit, mis, wr_en;
    logic           c_we;
    logic [1:0]     c_op;
    logic [31:0]    c_addr, c_wdata, wlane;
    logic [AW-1:0]  idx;
    logic [3:0]     be;
    logic           unused_ok;

    // Zero-wait accesses commit on the capture edge, so live inputs are used while idle.
    assign idle    = (state_q == IDLE);
    assign c_we    = idle ? we    : we_q;
    assign c_op    = idle ? memOp : op_q;
    assign c_addr  = idle ? addr  : addr_q;
    assign c_wdata = idle ? wdata : wdata_q;
    assign idx     = c_addr[AW+1:2];

    always_comb begin
        be    = 4'b1111;
        wlane = c_wdata;
        case (c_op)
            2'b01: begin
                be    = c_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{c_wdata[15:0]}};
            end
            2'b10: begin
                be    = 4'b0001 << c_addr[1:0];
                wlane = {4{c_wdata[7:0]}};
            end
            default: ;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        case (c_op)
            2'b01:   mis = c_addr[0];
            2'b10:   mis = 1'b0;
            default: mis = |c_addr[1:0];
        endcase
    end
    assign err = err_q;
`else
    assign mis = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req) begin
                if (WAIT_CYCLES == 0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = CW'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    commit  = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rdata_d = mis ? 32'h0 : mem[idx];
            err_d   = mis;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (idle && req) begin
                we_q    <= we;
                op_q    <= memOp;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // Memory is never cleared; reset only blocks a commit on the same edge.
    assign wr_en = commit & c_we & ~mis & ~rst;
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    assign rdata     = rdata_q;
    assign ack       = (state_q == RESP);
    assign busy      = !idle;
    assign unused_ok = ^{c_addr[31:AW+2], err_q};
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus random accesses against a byte-level memory model.
module tb_dmem_ctrl;
    logic        clk, rst, req, we, sel;
    logic [1:0]  memOp;
    logic [31:0] addr, wdata;
    logic        req1, req2, ack1, ack2, busy1, busy2, err1, err2;
    logic [31:0] rdata1, rdata2;
    logic [31:0] rdata;
    logic        ack, busy, err;

    int checks = 0;
    int errors = 0;
    logic [7:0]  mem_b [4096];
    logic [31:0] last_rd;
    logic        last_err;

    assign req1  = req & ~sel;
    assign req2  = req & sel;
    assign rdata = sel ? rdata2 : rdata1;
    assign ack   = sel ? ack2   : ack1;
    assign busy  = sel ? busy2  : busy1;
    assign err   = sel ? err2   : err1;

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req1), .we(we), .memOp(memOp), .addr(addr),
        .wdata(wdata), .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1));

    dmem_ctrl #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req2), .we(we), .memOp(memOp), .addr(addr),
        .wdata(wdata), .rdata(rdata2), .ack(ack2), .busy(busy2), .err(err2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        int b;
        b = int'(a[11:0]) & 32'hFFC;
        return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    endfunction

    // Reference: an access touches n consecutive bytes starting at the n-aligned address.
    task automatic mdl(input bit w, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic e);
        int n, base;
        bit m;
        n = (op == 2'b01) ? 2 : (op == 2'b10) ? 1 : 4;
        m = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        m = (int'(a[1:0]) % n) != 0;
`endif
        base = int'(a[11:0]) & ~(n - 1);
        rd = m ? 32'h0 : word_of(a);
        e  = m;
        if (w && !m)
            for (int i = 0; i < n; i++) mem_b[(base + i) % 4096] = d[8*i +: 8];
    endtask

    task automatic acc(input bit w, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input bit chk_rd, input logic [31:0] exp_rd,
                       input logic exp_err, input string tag);
        int c, bc, wc;
        wc = sel ? 0 : 2;
        bc = 0;
        @(negedge clk);
        req = 1'b1; we = w; memOp = op; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = $urandom; memOp = 2'($urandom); addr = $urandom; wdata = $urandom;
        for (c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (busy) bc++;
            if (ack) break;
        end
        last_rd  = rdata;
        last_err = err;
        chk({tag, "_lat"}, c, wc + 1);
        chk({tag, "_busy"}, bc, wc + 1);
        if (chk_rd) chk({tag, "_rd"}, last_rd, exp_rd);
        chk({tag, "_err"}, {31'h0, last_err}, {31'h0, exp_err});
        @(negedge clk);
        chk({tag, "_idle"}, {30'h0, busy, ack}, 32'h0);
    endtask

    task automatic macc(input bit w, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
        logic [31:0] rd;
        logic e;
        mdl(w, op, a, d, rd, e);
        acc(w, op, a, d, 1'b1, rd, e, tag);
    endtask

    initial begin
        int nack, last, extra;
        logic [31:0] exp_w;
        sel = 1'b0; rst = 1'b1; req = 1'b0; we = 1'b0; memOp = 2'b00; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_flags", {29'h0, busy, ack, err}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            mdl(1'b1, 2'b00, 32'(i * 4), 32'h0, exp_w, last_err);
            acc(1'b1, 2'b00, 32'(i * 4), 32'h0, 1'b0, 32'h0, 1'b0, "init");
        end

        macc(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, "w029");
        macc(1'b0, 2'b00, 32'h10, 32'h0, "r029");
        chk("r029_const", last_rd, 32'hDEADBEEF);

        macc(1'b1, 2'b00, 32'h20, 32'h11223344, "w030a");
        macc(1'b1, 2'b10, 32'h22, 32'h000000AA, "w030b");
        macc(1'b1, 2'b01, 32'h20, 32'h00005566, "w030c");
        macc(1'b0, 2'b00, 32'h20, 32'h0, "r030");
        chk("r030_const", last_rd, 32'h11AA5566);
        macc(1'b1, 2'b00, 32'h20, 32'h0BADF00D, "w022");
        chk("w022_prewrite", last_rd, 32'h11AA5566);

        // Continuous req: one access per 4 cycles, never one while busy.
        @(negedge clk);
        req = 1'b1; we = 1'b0; memOp = 2'b00; addr = 32'h10;
        exp_w = word_of(32'h10);
        nack = 0; last = -1;
        for (int c = 1; c <= 40 && nack < 3; c++) begin
            @(negedge clk);
            if (ack) begin
                if (last >= 0) chk("b2b_gap", c - last, 4);
                chk("b2b_rd", rdata, exp_w);
                last = c;
                nack++;
            end
        end
        req = 1'b0;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack) extra++;
        end
        chk("b2b_nack", nack, 3);
        chk("b2b_extra", extra, 0);

        // Reset during WAIT of a write drops it.
        @(negedge clk);
        req = 1'b1; we = 1'b1; memOp = 2'b00; addr = 32'h40; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("rstw_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_rdata", rdata, 32'h0);
        chk("rstw_flags", {29'h0, busy, ack, err}, 32'h0);
        rst = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) extra++;
        end
        chk("rstw_noack", extra, 0);
        macc(1'b0, 2'b00, 32'h40, 32'h0, "rstw_rd");
        chk("rstw_const", last_rd, 32'h0);

        macc(1'b1, 2'b00, 32'h1000, 32'h12345678, "w033");
        macc(1'b0, 2'b00, 32'h0, 32'h0, "r033");
        chk("r033_const", last_rd, 32'h12345678);

        macc(1'b1, 2'b00, 32'h31, 32'hFFFFFFFF, "w034");
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("w034_err", {31'h0, last_err}, 32'h1);
        chk("w034_rd", last_rd, 32'h0);
        macc(1'b0, 2'b00, 32'h30, 32'h0, "r034");
        chk("r034_const", last_rd, 32'h0);
`else
        chk("w034_err", {31'h0, last_err}, 32'h0);
        macc(1'b0, 2'b00, 32'h30, 32'h0, "r034");
        chk("r034_const", last_rd, 32'hFFFFFFFF);
`endif

        for (int i = 0; i < 60; i++)
            macc(1'($urandom), 2'($urandom), $urandom & 32'hFFFF_F0FF, $urandom, "rnd");

        // Zero-wait instance, 16 words: 0x44 aliases 0x04.
        sel = 1'b1;
        acc(1'b1, 2'b00, 32'h44, 32'h12345678, 1'b0, 32'h0, 1'b0, "z_wr");
        acc(1'b1, 2'b10, 32'h07, 32'h000000EE, 1'b1, 32'h12345678, 1'b0, "z_wb");
        acc(1'b0, 2'b00, 32'h04, 32'h0, 1'b1, 32'hEE345678, 1'b0, "z_rd");
        sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
